// File: rtl/intc_prio_seq_if.sv
// Signal bundle between peripheral request sources, the priority sequencer and the CPU.
// The sequencer drives the slave side. fsm_state exposes the controller state for debug.
interface intc_prio_seq_if #(
    parameter int NCH  = 9,
    parameter int NBUS = 3,
    parameter int CW   = 4
);
    logic [NBUS*NCH-1:0] req;
    logic [NCH-1:0]      en;
    logic                mask_wr;
    logic [NCH-1:0]      mask_data;
    logic                ack;

    logic [NBUS-1:0]     bus_req;
    logic                irq_valid;
    logic [1:0]          irq_bus;
    logic [CW-1:0]       irq_chan;
    logic [NBUS*NCH-1:0] pend;
    logic [1:0]          fsm_state;

    // Handshake: irq_valid is "valid" and ack is "ready". A transfer happens on a rising
    // CK edge where both are high. While irq_valid is high, irq_bus/irq_chan do not change
    // and irq_valid is not withdrawn. ack has no effect while irq_valid is low.
    modport master (
        output req, en, mask_wr, mask_data, ack,
        input  bus_req, irq_valid, irq_bus, irq_chan, pend, fsm_state
    );

    modport slave (
        input  req, en, mask_wr, mask_data, ack,
        output bus_req, irq_valid, irq_bus, irq_chan, pend, fsm_state
    );
endinterface

// File: rtl/intc_prio_seq.sv
// Clocked priority interrupt sequencer: sticky pending bits across NBUS prioritised buses.
// It presents one (bus, channel) winner at a time and holds it until that winner is acknowledged.
module intc_prio_seq #(
    parameter int NCH     = 9,
    parameter int NBUS    = 3,
    parameter int CW      = 4,
    parameter int RR_MODE = 0
) (
    input logic             CK,
    input logic             RST_N,
    intc_prio_seq_if.slave  irq_if
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [NBUS*NCH-1:0]   pend_q;
    logic [NBUS*NCH-1:0]   clr;
    logic [NBUS*NCH-1:0]   elig;
    logic [NCH-1:0]        mask_q;
    logic [NBUS-1:0]       bus_req_q;
    logic [NBUS-1:0]       bus_any;
    logic [CW-1:0]         rr_ptr_q [NBUS];
    logic [1:0]            irq_bus_q, irq_bus_d;
    logic [CW-1:0]         irq_chan_q, irq_chan_d;
    logic                  win_found;
    logic [1:0]            win_bus;
    logic [CW-1:0]         win_chan;
    logic                  accept;

    // With round-robin, channels above ptr rank before those at or below it.
    // The lowest index wins inside each group.
    function automatic logic [CW-1:0] pick_chan(input logic [NCH-1:0] row,
                                                input logic [CW-1:0]  ptr);
        logic [CW-1:0] sel;
        sel = '0;
        if (RR_MODE != 0) begin
            for (int c = NCH - 1; c >= 0; c--) begin
                if (row[c] && (CW'(c) <= ptr)) sel = CW'(c);
            end
            for (int c = NCH - 1; c >= 0; c--) begin
                if (row[c] && (CW'(c) > ptr)) sel = CW'(c);
            end
        end else begin
            for (int c = NCH - 1; c >= 0; c--) begin
                if (row[c]) sel = CW'(c);
            end
        end
        return sel;
    endfunction

    always_comb begin
        elig    = '0;
        bus_any = '0;
        for (int b = 0; b < NBUS; b++) begin
            elig[b*NCH +: NCH] = pend_q[b*NCH +: NCH] & irq_if.en & ~mask_q;
            bus_any[b]         = |elig[b*NCH +: NCH];
        end
    end

    // Scanning from the lowest-priority bus upward lets bus 0 overwrite everything else.
    always_comb begin
        win_found = 1'b0;
        win_bus   = '0;
        win_chan  = '0;
        for (int b = NBUS - 1; b >= 0; b--) begin
            if (bus_any[b]) begin
                win_found = 1'b1;
                win_bus   = 2'(b);
                win_chan  = pick_chan(elig[b*NCH +: NCH], rr_ptr_q[b]);
            end
        end
    end

    assign accept = (state_q == PRESENT) && irq_if.ack;

    always_comb begin
        clr = '0;
        for (int i = 0; i < NBUS*NCH; i++) begin
            clr[i] = accept && (irq_bus_q == 2'(i / NCH)) && (irq_chan_q == CW'(i % NCH));
        end
    end

    always_comb begin
        state_d    = state_q;
        irq_bus_d  = irq_bus_q;
        irq_chan_d = irq_chan_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d    = PRESENT;
                    irq_bus_d  = win_bus;
                    irq_chan_d = win_chan;
                end
            end
            PRESENT: begin
                if (irq_if.ack) state_d = GAP;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            mask_q     <= '0;
            bus_req_q  <= '0;
            irq_bus_q  <= '0;
            irq_chan_q <= '0;
            for (int b = 0; b < NBUS; b++) rr_ptr_q[b] <= '0;
        end else begin
            state_q    <= state_d;
            irq_bus_q  <= irq_bus_d;
            irq_chan_q <= irq_chan_d;
            // A request on the bit being acknowledged wins, so that entry arms again.
            pend_q     <= (pend_q & ~clr) | irq_if.req;
            bus_req_q  <= bus_any;
            if (irq_if.mask_wr) mask_q <= irq_if.mask_data;
            for (int b = 0; b < NBUS; b++) begin
                if (accept && (irq_bus_q == 2'(b))) rr_ptr_q[b] <= irq_chan_q;
            end
        end
    end

    assign irq_if.bus_req   = bus_req_q;
    assign irq_if.irq_valid = (state_q == PRESENT);
    assign irq_if.irq_bus   = irq_bus_q;
    assign irq_if.irq_chan  = irq_chan_q;
    assign irq_if.pend      = pend_q;
    assign irq_if.fsm_state = state_q;

endmodule

// File: tb/tb_intc_prio_seq.sv
// Bench for intc_prio_seq: one fixed-priority and one round-robin instance run in lockstep
// against a behavioural model, with directed scenarios followed by randomized traffic.
module tb_intc_prio_seq;
    localparam int NCH  = 9;
    localparam int NBUS = 3;
    localparam int CW   = 4;
    localparam int N    = NBUS * NCH;
    localparam int W    = 2 + CW;

    logic           CK = 1'b0;
    logic           RST_N = 1'b0;
    logic [N-1:0]   req;
    logic [NCH-1:0] en;
    logic           mask_wr;
    logic [NCH-1:0] mask_data;
    logic           ack;

    int n_checks = 0;
    int n_errors = 0;

    intc_prio_seq_if #(.NCH(NCH), .NBUS(NBUS), .CW(CW)) if0 ();
    intc_prio_seq_if #(.NCH(NCH), .NBUS(NBUS), .CW(CW)) if1 ();

    assign if0.req = req;  assign if0.en = en;  assign if0.mask_wr = mask_wr;
    assign if0.mask_data = mask_data;  assign if0.ack = ack;
    assign if1.req = req;  assign if1.en = en;  assign if1.mask_wr = mask_wr;
    assign if1.mask_data = mask_data;  assign if1.ack = ack;

    intc_prio_seq #(.NCH(NCH), .NBUS(NBUS), .CW(CW), .RR_MODE(0)) dut0 (
        .CK(CK), .RST_N(RST_N), .irq_if(if0.slave));
    intc_prio_seq #(.NCH(NCH), .NBUS(NBUS), .CW(CW), .RR_MODE(1)) dut1 (
        .CK(CK), .RST_N(RST_N), .irq_if(if1.slave));

    // ---------------- clock / reset ----------------
    always #5 CK = ~CK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (index 0 = fixed, 1 = round-robin) ----------------
    bit  m_pend  [2][NBUS][NCH];
    bit  m_breq  [2][NBUS];
    int  m_ptr   [2][NBUS];
    bit  m_valid [2];
    bit  m_gap   [2];
    int  m_bus   [2];
    int  m_chan  [2];
    bit  m_mask  [NCH];
    bit  prev_valid [2];
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int b = 0; b < NBUS; b++) begin
                for (int c = 0; c < NCH; c++) m_pend[m][b][c] = 0;
                m_breq[m][b] = 0;
                m_ptr[m][b]  = 0;
            end
            m_valid[m] = 0; m_gap[m] = 0; m_bus[m] = 0; m_chan[m] = 0;
            prev_valid[m] = 0;
        end
        for (int c = 0; c < NCH; c++) m_mask[c] = 0;
        exp_q0.delete();
        exp_q1.delete();
    endtask

    function automatic bit m_elig(int m, int b, int c);
        return m_pend[m][b][c] && en[c] && !m_mask[c];
    endfunction

    // Lowest bus first; within it, index order or wrap-around search after the last grant.
    task automatic m_winner(input int m, output bit found, output int wb, output int wc);
        int c;
        found = 0; wb = 0; wc = 0;
        for (int b = 0; b < NBUS && !found; b++) begin
            for (int k = 0; k < NCH && !found; k++) begin
                c = (m == 1) ? (m_ptr[m][b] + 1 + k) % NCH : k;
                if (m_elig(m, b, c)) begin found = 1; wb = b; wc = c; end
            end
        end
    endtask

    task automatic model_step();
        bit nb [NBUS];
        bit found;
        int wb, wc;
        logic [W-1:0] e;
        for (int m = 0; m < 2; m++) begin
            for (int b = 0; b < NBUS; b++) begin
                nb[b] = 0;
                for (int c = 0; c < NCH; c++) if (m_elig(m, b, c)) nb[b] = 1;
            end
            m_winner(m, found, wb, wc);
            if (m_valid[m] && ack) m_pend[m][m_bus[m]][m_chan[m]] = 0;
            for (int b = 0; b < NBUS; b++)
                for (int c = 0; c < NCH; c++)
                    if (req[b*NCH + c]) m_pend[m][b][c] = 1;
            for (int b = 0; b < NBUS; b++) m_breq[m][b] = nb[b];
            if (m_valid[m]) begin
                if (ack) begin
                    m_valid[m] = 0;
                    m_gap[m]   = 1;
                    m_ptr[m][m_bus[m]] = m_chan[m];
                end
            end else if (m_gap[m]) begin
                m_gap[m] = 0;
            end else if (found) begin
                m_valid[m] = 1; m_bus[m] = wb; m_chan[m] = wc;
                e = {wb[1:0], wc[CW-1:0]};
                if (m == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
            end
        end
        if (mask_wr) for (int c = 0; c < NCH; c++) m_mask[c] = mask_data[c];
    endtask

    // ---------------- scoreboard ----------------
    task automatic compare_one(input int m, input logic [N-1:0] pend, input logic [NBUS-1:0] breq,
                               input logic valid, input logic [1:0] bus, input logic [CW-1:0] chan);
        logic [N-1:0]    ep;
        logic [NBUS-1:0] eb;
        logic [W-1:0]    e;
        for (int b = 0; b < NBUS; b++) begin
            eb[b] = m_breq[m][b];
            for (int c = 0; c < NCH; c++) ep[b*NCH + c] = m_pend[m][b][c];
        end
        check($sformatf("pend_m%0d", m), pend, ep);
        check($sformatf("bus_req_m%0d", m), breq, eb);
        check($sformatf("irq_valid_m%0d", m), valid, m_valid[m]);
        if (valid && m_valid[m]) begin
            check($sformatf("irq_bus_m%0d", m), bus, m_bus[m]);
            check($sformatf("irq_chan_m%0d", m), chan, m_chan[m]);
        end
        if (valid && !prev_valid[m]) begin
            if (m == 0) begin
                check("grant_expected_m0", exp_q0.size() != 0, 1);
                if (exp_q0.size() != 0) begin
                    e = exp_q0.pop_front();
                    check("grant_m0", {bus, chan}, e);
                end
            end else begin
                check("grant_expected_m1", exp_q1.size() != 0, 1);
                if (exp_q1.size() != 0) begin
                    e = exp_q1.pop_front();
                    check("grant_m1", {bus, chan}, e);
                end
            end
        end
        prev_valid[m] = valid;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        model_step();
        @(posedge CK); #1;
        compare_one(0, if0.pend, if0.bus_req, if0.irq_valid, if0.irq_bus, if0.irq_chan);
        compare_one(1, if1.pend, if1.bus_req, if1.irq_valid, if1.irq_bus, if1.irq_chan);
    endtask

    task automatic ack_once();
        ack = 1'b1; cycle(); ack = 1'b0;
    endtask

    task automatic wait_present(input int budget);
        int n;
        n = 0;
        while (!if0.irq_valid && n < budget) begin cycle(); n++; end
        check("present_timeout", if0.irq_valid, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid0"}, if0.irq_valid, 0);  check({tag, "_valid1"}, if1.irq_valid, 0);
        check({tag, "_pend0"},  if0.pend, 0);       check({tag, "_pend1"},  if1.pend, 0);
        check({tag, "_breq0"},  if0.bus_req, 0);    check({tag, "_breq1"},  if1.bus_req, 0);
        check({tag, "_bus0"},   if0.irq_bus, 0);    check({tag, "_chan0"},  if0.irq_chan, 0);
        check({tag, "_state0"}, if0.fsm_state, 0);  check({tag, "_state1"}, if1.fsm_state, 0);
    endtask

    task automatic mid_reset();
        RST_N = 1'b0;
        #2;
        check_zero("async_reset");
        model_reset();
        #3;
        RST_N = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int g0 [5];
    int g1 [5];
    int exp_rr [5] = '{1, 3, 6, 1, 3};
    int n0, n1;

    initial begin
        req = '0; en = '1; mask_wr = 1'b0; mask_data = '0; ack = 1'b0;
        model_reset();
        repeat (2) @(posedge CK);
        #1;
        check_zero("reset");
        RST_N = 1'b1;

        // Priority across buses and bus_req history
        req[5] = 1'b1; req[NCH + 0] = 1'b1; req[2*NCH + 1] = 1'b1;
        cycle();
        req = '0;
        check("lat_valid_t1", if0.irq_valid, 0);
        check("lat_breq_t1", if0.bus_req, 3'b000);
        cycle();
        check("lat_valid_t2", if0.irq_valid, 1);
        check("prio_first", {if0.irq_bus, if0.irq_chan}, {2'd0, 4'd5});
        check("prio_breq_111", if0.bus_req, 3'b111);
        ack_once();
        wait_present(10);
        check("prio_second", {if0.irq_bus, if0.irq_chan}, {2'd1, 4'd0});
        check("prio_breq_110", if0.bus_req, 3'b110);
        ack_once();
        wait_present(10);
        check("prio_third", {if0.irq_bus, if0.irq_chan}, {2'd2, 4'd1});
        check("prio_breq_100", if0.bus_req, 3'b100);
        ack_once();
        cycle();
        check("prio_breq_000", if0.bus_req, 3'b000);

        // Mask and enable gating
        mask_wr = 1'b1; mask_data = 9'h004; cycle(); mask_wr = 1'b0;
        req[2] = 1'b1; req[7] = 1'b1; cycle(); req = '0;
        wait_present(10);
        check("mask_win_ch7", {if0.irq_bus, if0.irq_chan}, {2'd0, 4'd7});
        check("mask_ch2_pending", if0.pend[2], 1);
        ack_once();
        mask_wr = 1'b1; mask_data = '0; cycle(); mask_wr = 1'b0;
        wait_present(10);
        check("unmask_ch2", {if0.irq_bus, if0.irq_chan}, {2'd0, 4'd2});
        ack_once();
        en[3] = 1'b0; req[3] = 1'b1; cycle(); req = '0;
        repeat (6) begin
            cycle();
            check("en_gated_valid", if0.irq_valid, 0);
        end
        en = '1;
        wait_present(10);
        check("en_restored_ch3", {if0.irq_bus, if0.irq_chan}, {2'd0, 4'd3});
        ack_once();

        // Presentation held while higher-priority requests arrive
        req[2*NCH + 4] = 1'b1; cycle(); req = '0;
        wait_present(10);
        check("hold_first", {if0.irq_bus, if0.irq_chan}, {2'd2, 4'd4});
        req[0] = 1'b1;
        repeat (5) begin
            cycle();
            check("hold_stable", {if0.irq_valid, if0.irq_bus, if0.irq_chan}, {1'b1, 2'd2, 4'd4});
        end
        req = '0;
        ack_once();
        wait_present(10);
        check("hold_next", {if0.irq_bus, if0.irq_chan}, {2'd0, 4'd0});
        ack_once();

        // Set/clear race on the acknowledged bit
        req[11] = 1'b1; cycle(); req = '0;
        wait_present(10);
        check("race_first", {if0.irq_bus, if0.irq_chan}, {2'd1, 4'd2});
        req[11] = 1'b1; ack = 1'b1; cycle(); ack = 1'b0; req = '0;
        check("race_rearmed", if0.pend[11], 1);
        wait_present(10);
        check("race_again", {if0.irq_bus, if0.irq_chan}, {2'd1, 4'd2});

        // Reset while presenting
        mid_reset();
        repeat (4) begin
            cycle();
            check("post_reset_idle", if0.irq_valid, 0);
        end

        // Round-robin against fixed order with three channels held high
        n0 = 0; n1 = 0;
        for (int i = 0; i < 5; i++) begin g0[i] = -1; g1[i] = -1; end
        req[1] = 1'b1; req[3] = 1'b1; req[6] = 1'b1; ack = 1'b1;
        for (int i = 0; i < 40 && (n0 < 5 || n1 < 5); i++) begin
            cycle();
            if (if0.irq_valid && n0 < 5) begin g0[n0] = int'(if0.irq_chan); n0++; end
            if (if1.irq_valid && n1 < 5) begin g1[n1] = int'(if1.irq_chan); n1++; end
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_grant%0d", i), g1[i], exp_rr[i]);
            check($sformatf("fixed_grant%0d", i), g0[i], 1);
        end
        req = '0;
        repeat (20) cycle();
        ack = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            for (int k = 0; k < N; k++) req[k] = ($urandom_range(0, 9) == 0);
            en        = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '1;
            mask_wr   = ($urandom_range(0, 15) == 0);
            mask_data = NCH'($urandom) & NCH'($urandom);
            ack       = 1'($urandom_range(0, 1));
            cycle();
        end

        // Drain everything left pending
        req = '0; en = '1; mask_wr = 1'b1; mask_data = '0; ack = 1'b1;
        cycle();
        mask_wr = 1'b0;
        repeat (100) cycle();
        ack = 1'b0;
        check("drain_pend0", if0.pend, 0);
        check("drain_pend1", if1.pend, 0);
        check("drain_q0", exp_q0.size(), 0);
        check("drain_q1", exp_q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
